inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Parametrised fetch stage. Holds PC; looks up icache, fetches misses from the memory controller and fills the icache.
//  Predicts the next PC: JAL statically, B-type via the predictor.
//  Buffers fetched instructions in a DEPTH-entry queue drained by the decoder with valid/ready.
//  Flushes on ROB redirect.
// PARAMETERS
//  XLEN      32           address/instruction width
//  IQ_DEPTH  4            fetch queue entries (power of 2, >=2)
//  RESET_PC  32'h0        PC after reset
// PORTS
//  clk_in               in   1     clock
//  rst_in               in   1     synchronous reset, active-low (0 = reset)
//  rdy_in               in   1     global enable; 0 freezes all state
//  ic_to_if_hit         in   1     icache hit for if_to_ic_addr (same cycle)
//  ic_to_if_inst        in   XLEN  hit instruction
//  if_to_ic_addr        out  XLEN  lookup/fill address
//  if_to_ic_fill        out  1     1-cycle pulse: write if_to_ic_fill_inst at if_to_ic_addr
//  if_to_ic_fill_inst   out  XLEN  fill data
//  if_to_mc_valid       out  1     fetch request, held until mc_to_if_ready
//  if_to_mc_pc          out  XLEN  request address, stable while valid
//  mc_to_if_ready       in   1     1-cycle pulse: mc_to_if_inst valid
//  mc_to_if_inst        in   XLEN  fetched instruction
//  if_to_pr_pc          out  XLEN  PC being predicted (= current PC)
//  pr_to_if_taken       in   1     predictor says taken (combinational)
//  rob_to_if_redirect   in   1     mispredict/jalr redirect, 1 cycle
//  rob_to_if_target     in   XLEN  redirect PC
//  if_to_dc_valid       out  1     queue head valid
//  dc_to_if_ready       in   1     decoder accepts head
//  if_to_dc_inst        out  XLEN  head instruction
//  if_to_dc_pc          out  XLEN  head PC
//  if_to_dc_pred_taken  out  1     head was predicted taken
// BEHAVIOUR
//  Reset (rst_in=0 at edge): PC=RESET_PC, state=IDLE, queue empty, discard=0; all outputs 0.
//  rdy_in=0: no state changes, no pulses; reset still has priority over rdy_in.
//  States: IDLE, WAIT_MEM.
//  IDLE, queue not full: if_to_ic_addr=PC. On hit: enqueue {inst,PC,pred}, PC<=nextPC in the same cycle.
//    Throughput 1/cycle.
//  IDLE, miss: if_to_mc_valid=1, if_to_mc_pc=PC, go WAIT_MEM.
//  IDLE, queue full: no lookup issued, no request, PC holds.
//  WAIT_MEM on mc_to_if_ready: if_to_ic_fill pulses 1 cycle with the latched pc/inst.
//    If discard=0: enqueue and PC<=nextPC. If discard=1: no enqueue and discard<=0.
//    In both cases go to IDLE; if_to_mc_valid drops the same edge.
//  WAIT_MEM needs no queue-space check: a request is only issued while count<IQ_DEPTH.
//  nextPC from inst[6:0]:
//    JAL (1101111)            -> PC + sext(imm_j)
//    BRANCH (1100011), taken  -> PC + sext(imm_b)
//    anything else            -> PC + 4
//  JALR is not predicted; the ROB corrects it. pred_taken=1 for JAL or a taken branch.
//  Adds are modulo 2^XLEN and wrap silently.
//  Redirect has top priority. In that cycle: queue cleared, PC<=rob_to_if_target, no enqueue.
//    In WAIT_MEM: stay, discard<=1, request is kept alive.
//    In IDLE: hit/miss result of that cycle is ignored.
//  Queue (circular FIFO): deq when if_to_dc_valid & dc_to_if_ready.
//    Simultaneous enq+deq keeps count; full means count==IQ_DEPTH.
//    enq is blocked when full even if a deq happens that cycle.
//    Head outputs are registered from the queue RAM. Pointers wrap mod IQ_DEPTH.
//  Redirect in the same cycle as mc_to_if_ready: fill still pulses, data is dropped, discard stays 0, go to IDLE.
//  Latency: hit to if_to_dc_valid = 1 cycle; miss = mem latency + 1.
// STRUCTURE
//  Shared defs header: XLEN default, opcode constants (OPC_JAL, OPC_BRANCH, OPC_JALR),
//    imm_b/imm_j extraction macros, STATUS_IDLE/STATUS_WAIT encodings.
//  Sub-module fetch_queue #(WIDTH=2*XLEN+1, DEPTH=IQ_DEPTH): enq/deq/flush/full/empty.
//  Top level: PC register, FSM, next-PC adders.
// TESTING
//  1 Reset RESET_PC=0; icache always hits with addi; dc_ready=1
//    -> PCs 0,4,8,... appear on if_to_dc_pc, one per cycle.
//  2 Miss at 0x10; mc returns 0x00000013 after 5 cycles
//    -> if_to_mc_valid high for 5 cycles, fill pulse addr 0x10, enqueue, PC=0x14.
//  3 Branch at 0x20, imm_b=-8, pr_taken=1 -> next fetch 0x18, pred_taken=1.
//    JAL +0x100 at 0x40 -> next fetch 0x140.
//  4 dc_ready=0 with hits -> exactly IQ_DEPTH entries queued, PC stalls.
//    Release -> drains in order, no loss or duplicates.
//  5 Redirect to 0x200 mid-miss -> queue empties; late mc response fills cache only,
//    no enqueue; next request is for 0x200.
//  6 rst_in=0 mid-WAIT_MEM; rdy_in=0 for 3 cycles
//    -> outputs zero / state frozen respectively; no lost or extra entries.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch-stage definitions: default width, RV32 opcodes, FSM encoding
// and immediate extraction helpers for next-PC prediction.
package inst_fetch_unit_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic {
    STATUS_IDLE = 1'b0,
    STATUS_WAIT = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_queue.sv
// Circular FIFO between fetch and decode; head is read from the register
// storage and forced to zero while empty.
module fetch_queue #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             enq,
  input  logic             deq,
  input  logic [WIDTH-1:0] enq_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_enq;
  logic             do_deq;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign do_enq = enq & ~full;
  assign do_deq = deq & ~empty;

  assign head_data = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_enq) begin
          mem[wr_ptr] <= enq_data;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (do_deq) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (do_enq && !do_deq) begin
          count <= count + (AW+1)'(1);
        end else if (!do_enq && do_deq) begin
          count <= count - (AW+1)'(1);
        end
      end
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC register, icache lookup with memory-controller miss path,
// static JAL / predicted branch next-PC, and the decoder-facing queue.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              IQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            ic_to_if_hit,
  input  logic [XLEN-1:0] ic_to_if_inst,
  output logic [XLEN-1:0] if_to_ic_addr,
  output logic            if_to_ic_fill,
  output logic [XLEN-1:0] if_to_ic_fill_inst,
  output logic            if_to_mc_valid,
  output logic [XLEN-1:0] if_to_mc_pc,
  input  logic            mc_to_if_ready,
  input  logic [XLEN-1:0] mc_to_if_inst,
  output logic [XLEN-1:0] if_to_pr_pc,
  input  logic            pr_to_if_taken,
  input  logic            rob_to_if_redirect,
  input  logic [XLEN-1:0] rob_to_if_target,
  output logic            if_to_dc_valid,
  input  logic            dc_to_if_ready,
  output logic [XLEN-1:0] if_to_dc_inst,
  output logic [XLEN-1:0] if_to_dc_pc,
  output logic            if_to_dc_pred_taken
);

  localparam int QW = 2 * XLEN + 1;

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            discard;

  logic            q_full;
  logic            q_empty;
  logic            q_enq;
  logic [QW-1:0]   q_head;
  logic            lookup;
  logic            mem_done;
  logic [XLEN-1:0] enq_inst;
  logic            enq_pred;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] jal_off;
  logic [XLEN-1:0] br_off;

  assign lookup   = (state == STATUS_IDLE) & ~q_full;
  assign mem_done = (state == STATUS_WAIT) & mc_to_if_ready;
  assign enq_inst = (state == STATUS_IDLE) ? ic_to_if_inst : mc_to_if_inst;
  assign jal_off  = XLEN'($signed(imm_j(enq_inst[31:0])));
  assign br_off   = XLEN'($signed(imm_b(enq_inst[31:0])));
  assign q_enq    = ~rob_to_if_redirect &
                    ((lookup & ic_to_if_hit) | (mem_done & ~discard));

  // While a miss is outstanding pc equals req_pc unless redirected,
  // and a redirected response is discarded, so pc is always the base.
  always_comb begin
    pc_next  = pc + XLEN'(4);
    enq_pred = 1'b0;
    if (enq_inst[6:0] == OPC_JAL) begin
      pc_next  = pc + jal_off;
      enq_pred = 1'b1;
    end else if (enq_inst[6:0] == OPC_BRANCH && pr_to_if_taken) begin
      pc_next  = pc + br_off;
      enq_pred = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state   <= STATUS_IDLE;
      pc      <= RESET_PC;
      req_pc  <= '0;
      discard <= 1'b0;
    end else if (rdy_in) begin
      unique case (state)
        STATUS_IDLE: begin
          if (rob_to_if_redirect) begin
            pc <= rob_to_if_target;
          end else if (lookup) begin
            if (ic_to_if_hit) begin
              pc <= pc_next;
            end else begin
              req_pc <= pc;
              state  <= STATUS_WAIT;
            end
          end
        end
        STATUS_WAIT: begin
          if (mc_to_if_ready) begin
            state   <= STATUS_IDLE;
            discard <= 1'b0;
            if (rob_to_if_redirect) begin
              pc <= rob_to_if_target;
            end else if (!discard) begin
              pc <= pc_next;
            end
          end else if (rob_to_if_redirect) begin
            pc      <= rob_to_if_target;
            discard <= 1'b1;
          end
        end
        default: state <= STATUS_IDLE;
      endcase
    end
  end

  fetch_queue #(
    .WIDTH (QW),
    .DEPTH (IQ_DEPTH)
  ) u_queue (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .en        (rdy_in),
    .flush     (rob_to_if_redirect),
    .enq       (q_enq),
    .deq       (if_to_dc_valid & dc_to_if_ready),
    .enq_data  ({enq_inst, (state == STATUS_IDLE) ? pc : req_pc, enq_pred}),
    .head_data (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign if_to_ic_addr      = (state == STATUS_WAIT) ? req_pc : (q_full ? '0 : pc);
  assign if_to_ic_fill      = rdy_in & mem_done;
  assign if_to_ic_fill_inst = if_to_ic_fill ? mc_to_if_inst : '0;
  assign if_to_mc_valid     = (state == STATUS_WAIT);
  assign if_to_mc_pc        = req_pc;
  assign if_to_pr_pc        = pc;

  assign if_to_dc_valid = ~q_empty;
  assign {if_to_dc_inst, if_to_dc_pc, if_to_dc_pred_taken} = q_head;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: next-PC vector table, hand-written
// miss/full/redirect/freeze sequences, then randomized run against a queue model.
module tb_inst_fetch_unit;

  localparam int DEPTH = 4;
  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam logic [31:0] JALR = 32'h0000_8067;

  logic        clk;
  logic        rst_in, rdy_in;
  logic        ic_to_if_hit;
  logic [31:0] ic_to_if_inst;
  logic [31:0] if_to_ic_addr;
  logic        if_to_ic_fill;
  logic [31:0] if_to_ic_fill_inst;
  logic        if_to_mc_valid;
  logic [31:0] if_to_mc_pc;
  logic        mc_to_if_ready;
  logic [31:0] mc_to_if_inst;
  logic [31:0] if_to_pr_pc;
  logic        pr_to_if_taken;
  logic        rob_to_if_redirect;
  logic [31:0] rob_to_if_target;
  logic        if_to_dc_valid;
  logic        dc_to_if_ready;
  logic [31:0] if_to_dc_inst;
  logic [31:0] if_to_dc_pc;
  logic        if_to_dc_pred_taken;

  int checks = 0;
  int failures = 0;

  inst_fetch_unit #(.XLEN(32), .IQ_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .ic_to_if_hit(ic_to_if_hit), .ic_to_if_inst(ic_to_if_inst),
    .if_to_ic_addr(if_to_ic_addr), .if_to_ic_fill(if_to_ic_fill),
    .if_to_ic_fill_inst(if_to_ic_fill_inst),
    .if_to_mc_valid(if_to_mc_valid), .if_to_mc_pc(if_to_mc_pc),
    .mc_to_if_ready(mc_to_if_ready), .mc_to_if_inst(mc_to_if_inst),
    .if_to_pr_pc(if_to_pr_pc), .pr_to_if_taken(pr_to_if_taken),
    .rob_to_if_redirect(rob_to_if_redirect), .rob_to_if_target(rob_to_if_target),
    .if_to_dc_valid(if_to_dc_valid), .dc_to_if_ready(dc_to_if_ready),
    .if_to_dc_inst(if_to_dc_inst), .if_to_dc_pc(if_to_dc_pc),
    .if_to_dc_pred_taken(if_to_dc_pred_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] exp_next;
    logic        exp_pred;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } entry_t;

  vec_t   vecs[9];
  entry_t mq[$];
  logic [31:0] m_pc, m_req;
  logic        m_wait, m_discard;

  function automatic logic [31:0] enc_b(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'd0, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
  endfunction

  function automatic logic [31:0] rand_inst();
    case ($urandom_range(0, 3))
      0:       return ADDI;
      1:       return enc_b(13'($urandom) & 13'h1FFE);
      2:       return enc_j(21'($urandom) & 21'h1FFFFE);
      default: return JALR;
    endcase
  endfunction

  // Reference next-PC: immediates rebuilt as signed integer sums of fields.
  function automatic void ref_next(input logic [31:0] pc, input logic [31:0] inst,
                                   input logic taken, output logic [31:0] npc,
                                   output logic pred);
    int off;
    off  = 4;
    pred = 1'b0;
    if (inst[6:0] == 7'b1101111) begin
      off = (inst[31] ? -1048576 : 0) + int'(inst[19:12]) * 4096 +
            int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
      pred = 1'b1;
    end else if (inst[6:0] == 7'b1100011 && taken) begin
      off = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048 +
            int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
      pred = 1'b1;
    end
    npc = pc + 32'(off);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic redirect, input logic [31:0] target,
                               input logic hit, input logic [31:0] inst,
                               input logic taken, input logic dc_ready);
    rob_to_if_redirect = redirect;
    rob_to_if_target   = target;
    ic_to_if_hit       = hit;
    ic_to_if_inst      = inst;
    pr_to_if_taken     = taken;
    dc_to_if_ready     = dc_ready;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        e_fill, p;
    logic [31:0] npc;
    entry_t      ent;

    rst_in = 1'b0; rdy_in = 1'b1;
    mc_to_if_ready = 1'b0; mc_to_if_inst = '0;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    tick(); tick();
    rst_in = 1'b1;
    #1;
    checkOutput("rst_dc_valid", if_to_dc_valid, 0);
    checkOutput("rst_mc_valid", if_to_mc_valid, 0);
    checkOutput("rst_fill", if_to_ic_fill, 0);
    checkOutput("rst_pr_pc", if_to_pr_pc, 0);
    checkOutput("rst_ic_addr", if_to_ic_addr, 0);

    // Streaming hits: one PC per cycle, enqueued head one cycle later.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, '0, 1'b1, ADDI, 1'b0, 1'b1);
      checkOutput("seq_ic_addr", if_to_ic_addr, 32'(4 * i));
      if (i > 0) begin
        checkOutput("seq_dc_valid", if_to_dc_valid, 1);
        checkOutput("seq_dc_pc", if_to_dc_pc, 32'(4 * (i - 1)));
      end
      tick();
    end

    vecs[0] = '{32'h20,       enc_b(13'h1FF8),    1'b1, 32'h18,       1'b1};
    vecs[1] = '{32'h40,       enc_j(21'h000100),  1'b0, 32'h140,      1'b1};
    vecs[2] = '{32'h20,       enc_b(13'h1FF8),    1'b0, 32'h24,       1'b0};
    vecs[3] = '{32'h100,      enc_j(21'h1FFFE0),  1'b0, 32'hE0,       1'b1};
    vecs[4] = '{32'h80,       JALR,               1'b1, 32'h84,       1'b0};
    vecs[5] = '{32'hFFFFFFFC, ADDI,               1'b0, 32'h0,        1'b0};
    vecs[6] = '{32'h0,        enc_b(13'h1FF8),    1'b1, 32'hFFFFFFF8, 1'b1};
    vecs[7] = '{32'h3000,     enc_b(13'h0FFE),    1'b1, 32'h3FFE,     1'b1};
    vecs[8] = '{32'h1000,     enc_j(21'h100000),  1'b0, 32'hFFF01000, 1'b1};
    foreach (vecs[k]) begin
      applyStimulus(1'b1, vecs[k].pc, 1'b0, ADDI, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, '0, 1'b1, vecs[k].inst, vecs[k].taken, 1'b1);
      checkOutput("vec_lookup", if_to_ic_addr, vecs[k].pc);
      tick();
      applyStimulus(1'b0, '0, 1'b1, ADDI, 1'b0, 1'b1);
      checkOutput("vec_next_pc", if_to_ic_addr, vecs[k].exp_next);
      checkOutput("vec_dc_pc", if_to_dc_pc, vecs[k].pc);
      checkOutput("vec_dc_inst", if_to_dc_inst, vecs[k].inst);
      checkOutput("vec_pred", if_to_dc_pred_taken, vecs[k].exp_pred);
      tick();
    end

    // Miss at 0x10 served after five cycles of an outstanding request.
    applyStimulus(1'b1, 32'h10, 1'b0, ADDI, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, ADDI, 1'b0, 1'b1);
    checkOutput("miss_addr", if_to_ic_addr, 32'h10);
    tick();
    for (int k = 1; k <= 5; k++) begin
      mc_to_if_ready = (k == 5);
      mc_to_if_inst  = ADDI;
      #1;
      checkOutput("miss_mc_valid", if_to_mc_valid, 1);
      checkOutput("miss_mc_pc", if_to_mc_pc, 32'h10);
      checkOutput("miss_dc_empty", if_to_dc_valid, 0);
      checkOutput("miss_fill", if_to_ic_fill, (k == 5) ? 1 : 0);
      if (k == 5) begin
        checkOutput("miss_fill_addr", if_to_ic_addr, 32'h10);
        checkOutput("miss_fill_inst", if_to_ic_fill_inst, ADDI);
      end
      tick();
    end
    mc_to_if_ready = 1'b0;
    applyStimulus(1'b0, '0, 1'b1, ADDI, 1'b0, 1'b1);
    checkOutput("miss_mc_drop", if_to_mc_valid, 0);
    checkOutput("miss_next_pc", if_to_ic_addr, 32'h14);
    checkOutput("miss_dc_pc", if_to_dc_pc, 32'h10);
    tick();

    // Decoder stalled: queue fills to DEPTH, then drains in order.
    applyStimulus(1'b1, 32'h400, 1'b0, ADDI, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, '0, 1'b1, ADDI, 1'b0, 1'b0);
      tick();
    end
    #1;
    checkOutput("full_pc_stall", if_to_pr_pc, 32'h400 + 32'(4 * DEPTH));
    checkOutput("full_no_lookup", if_to_ic_addr, 0);
    for (int r = 0; r < 6; r++) begin
      applyStimulus(1'b0, '0, 1'b1, ADDI, 1'b0, 1'b1);
      checkOutput("drain_valid", if_to_dc_valid, 1);
      checkOutput("drain_pc", if_to_dc_pc, 32'h400 + 32'(4 * r));
      tick();
    end

    // Redirect while a miss is outstanding: late data only fills the cache.
    applyStimulus(1'b1, 32'h500, 1'b0, ADDI, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b1, ADDI, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b1, ADDI, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, ADDI, 1'b0, 1'b0);
    checkOutput("rd_miss_addr", if_to_ic_addr, 32'h508);
    tick();
    applyStimulus(1'b1, 32'h200, 1'b0, ADDI, 1'b0, 1'b0);
    checkOutput("rd_q_before", if_to_dc_valid, 1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, ADDI, 1'b0, 1'b0);
    checkOutput("rd_q_flushed", if_to_dc_valid, 0);
    checkOutput("rd_req_alive", if_to_mc_valid, 1);
    checkOutput("rd_req_pc", if_to_mc_pc, 32'h508);
    checkOutput("rd_new_pc", if_to_pr_pc, 32'h200);
    mc_to_if_ready = 1'b1;
    #1;
    checkOutput("rd_late_fill", if_to_ic_fill, 1);
    checkOutput("rd_late_addr", if_to_ic_addr, 32'h508);
    tick();
    mc_to_if_ready = 1'b0;
    #1;
    checkOutput("rd_no_enq", if_to_dc_valid, 0);
    checkOutput("rd_idle", if_to_mc_valid, 0);
    checkOutput("rd_lookup", if_to_ic_addr, 32'h200);
    tick();
    checkOutput("rd_new_req", if_to_mc_pc, 32'h200);
    mc_to_if_ready = 1'b1;
    #1;
    tick();
    mc_to_if_ready = 1'b0;
    applyStimulus(1'b0, '0, 1'b1, ADDI, 1'b0, 1'b1);
    checkOutput("rd_enq_pc", if_to_dc_pc, 32'h200);

    // rdy_in low freezes an outstanding miss; reset mid-miss clears it.
    applyStimulus(1'b0, '0, 1'b0, ADDI, 1'b0, 1'b0);
    tick();
    rdy_in = 1'b0;
    mc_to_if_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("frz_mc_valid", if_to_mc_valid, 1);
      checkOutput("frz_no_fill", if_to_ic_fill, 0);
      checkOutput("frz_dc_valid", if_to_dc_valid, 1);
      tick();
    end
    rdy_in = 1'b1;
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    mc_to_if_ready = 1'b0;
    #1;
    checkOutput("rst_mid_mc", if_to_mc_valid, 0);
    checkOutput("rst_mid_dc", if_to_dc_valid, 0);
    checkOutput("rst_mid_pc", if_to_pr_pc, 0);

    // Randomized run against the transaction-level model.
    mq.delete();
    m_pc = '0; m_req = '0; m_wait = 1'b0; m_discard = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_in         = ($urandom_range(0, 99) != 0);
      rdy_in         = ($urandom_range(0, 9) != 0);
      mc_to_if_ready = if_to_mc_valid && ($urandom_range(0, 2) == 0);
      mc_to_if_inst  = rand_inst();
      applyStimulus($urandom_range(0, 19) == 0, $urandom & 32'h0000_FFFC,
                    $urandom_range(0, 9) < 7, rand_inst(),
                    1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6);
      e_fill = rdy_in && m_wait && mc_to_if_ready;
      checkOutput("rnd_dc_valid", if_to_dc_valid, (mq.size() > 0) ? 1 : 0);
      if (mq.size() > 0) begin
        checkOutput("rnd_dc_pc", if_to_dc_pc, mq[0].pc);
        checkOutput("rnd_dc_inst", if_to_dc_inst, mq[0].inst);
        checkOutput("rnd_dc_pred", if_to_dc_pred_taken, mq[0].pred);
      end
      checkOutput("rnd_mc_valid", if_to_mc_valid, m_wait);
      if (m_wait) checkOutput("rnd_mc_pc", if_to_mc_pc, m_req);
      checkOutput("rnd_fill", if_to_ic_fill, e_fill);
      if (e_fill) checkOutput("rnd_fill_addr", if_to_ic_addr, m_req);
      if (!m_wait && mq.size() < DEPTH) checkOutput("rnd_ic_addr", if_to_ic_addr, m_pc);
      checkOutput("rnd_pr_pc", if_to_pr_pc, m_pc);

      if (!rst_in) begin
        mq.delete();
        m_pc = '0; m_req = '0; m_wait = 1'b0; m_discard = 1'b0;
      end else if (rdy_in) begin
        automatic bit was_full = (mq.size() == DEPTH);
        automatic bit pop = (mq.size() > 0) && dc_to_if_ready;
        if (rob_to_if_redirect) begin
          mq.delete();
          m_pc = rob_to_if_target;
          if (m_wait) begin
            if (mc_to_if_ready) begin m_wait = 1'b0; m_discard = 1'b0; end
            else m_discard = 1'b1;
          end
        end else begin
          if (pop) void'(mq.pop_front());
          if (!m_wait) begin
            if (!was_full) begin
              if (ic_to_if_hit) begin
                ref_next(m_pc, ic_to_if_inst, pr_to_if_taken, npc, p);
                ent = '{ic_to_if_inst, m_pc, p};
                mq.push_back(ent);
                m_pc = npc;
              end else begin
                m_wait = 1'b1;
                m_req  = m_pc;
              end
            end
          end else if (mc_to_if_ready) begin
            if (!m_discard) begin
              ref_next(m_req, mc_to_if_inst, pr_to_if_taken, npc, p);
              ent = '{mc_to_if_inst, m_req, p};
              mq.push_back(ent);
              m_pc = npc;
            end
            m_discard = 1'b0;
            m_wait    = 1'b0;
          end
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
